// File: rtl/sap1_datapath_if.sv
// rtl/sap1_datapath_if.sv - control word, program port and status bundle of the SAP-1 datapath
interface sap1_datapath_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [11:0]       cw;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] bus_out;
  logic              carry;
  logic              zero;
  logic              halted;
  logic              bus_err;

  modport master (
    output cw, prog_we, prog_addr, prog_data,
    input  opcode, a_out, bus_out, carry, zero, halted, bus_err
  );

  modport slave (
    input  cw, prog_we, prog_addr, prog_data,
    output opcode, a_out, bus_out, carry, zero, halted, bus_err
  );
endinterface

// File: rtl/sap1_datapath.sv
// rtl/sap1_datapath.sv - SAP-1 datapath: PC, MAR, RAM, IR, A, B, add/sub unit and shared bus
module sap1_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic rst,
  sap1_datapath_if.slave io
);
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_carry;
  logic              r_zero;
  logic              r_halted;
  logic              r_bus_err;
  logic [DATA_W-1:0] r_ram [2**ADDR_W];

  logic w_hlt, w_pc_inc, w_pc_en, w_mem_load, w_mem_en, w_ir_load;
  logic w_ir_en, w_a_load, w_a_en, w_b_load, w_sub, w_adder_en;
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_bus;
  logic [2:0]        w_ndrv;
  logic              w_exec;

  assign w_hlt      = io.cw[11];
  assign w_pc_inc   = io.cw[10];
  assign w_pc_en    = io.cw[9];
  assign w_mem_load = io.cw[8];
  assign w_mem_en   = io.cw[7];
  assign w_ir_load  = io.cw[6];
  assign w_ir_en    = io.cw[5];
  assign w_a_load   = io.cw[4];
  assign w_a_en     = io.cw[3];
  assign w_b_load   = io.cw[2];
  assign w_sub      = io.cw[1];
  assign w_adder_en = io.cw[0];

  // Subtraction as A + ~B + 1, so carry out of the top bit means "no borrow".
  assign w_b_op = w_sub ? ~r_b : r_b;
  assign w_sum  = {1'b0, r_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_sub};

  assign w_ndrv = {2'b00, w_adder_en} + {2'b00, w_a_en} + {2'b00, w_mem_en}
                + {2'b00, w_ir_en} + {2'b00, w_pc_en};

  always_comb begin
    w_bus = '0;
    if (w_adder_en)    w_bus = w_sum[DATA_W-1:0];
    else if (w_a_en)   w_bus = r_a;
    else if (w_mem_en) w_bus = r_ram[r_mar];
    else if (w_ir_en)  w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
    else if (w_pc_en)  w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
  end

  // A program write steals the cycle: the control word is ignored for it.
  assign w_exec = !r_halted && !io.prog_we;

  always_ff @(posedge clk) begin
    if (io.prog_we) r_ram[io.prog_addr] <= io.prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_mar     <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_exec && (w_ndrv > 3'd1);
      if (w_exec) begin
        if (w_mem_load) r_mar <= w_bus[ADDR_W-1:0];
        if (w_ir_load)  r_ir  <= w_bus;
        if (w_a_load) begin
          r_a <= w_bus;
          if (w_adder_en) begin
            r_carry <= w_sum[DATA_W];
            r_zero  <= (w_sum[DATA_W-1:0] == '0);
          end
        end
        if (w_b_load) r_b      <= w_bus;
        if (w_pc_inc) r_pc     <= r_pc + 1'b1;
        if (w_hlt)    r_halted <= 1'b1;
      end
    end
  end

  assign io.opcode  = r_ir[DATA_W-1 -: 4];
  assign io.a_out   = r_a;
  assign io.bus_out = w_bus;
  assign io.carry   = r_carry;
  assign io.zero    = r_zero;
  assign io.halted  = r_halted;
  assign io.bus_err = r_bus_err;
endmodule

// File: tb/tb_sap1_datapath.sv
// tb/tb_sap1_datapath.sv - randomized and directed checks of sap1_datapath against a behavioural model
module tb_sap1_datapath;
  localparam logic [11:0] HLT = 12'h800, PC_INC = 12'h400, PC_EN = 12'h200,
    MEM_LOAD = 12'h100, MEM_EN = 12'h080, IR_LOAD = 12'h040, IR_EN = 12'h020,
    A_LOAD = 12'h010, A_EN = 12'h008, B_LOAD = 12'h004, SUB = 12'h002, ADDER_EN = 12'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sap1_datapath_if #(.DATA_W(8), .ADDR_W(4)) io ();
  sap1_datapath #(.DATA_W(8), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .io(io.master));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Reference state, kept as plain integers
  int m_mem [16];
  int m_pc, m_mar, m_ir, m_a, m_b, m_carry, m_zero, m_halt, m_err;
  bit m_init = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int alu_sum(input logic [11:0] cw);
    return cw[1] ? (m_a + 256 - m_b) : (m_a + m_b);
  endfunction

  function automatic int mbus(input logic [11:0] cw);
    if (cw[0]) return alu_sum(cw) % 256;
    if (cw[3]) return m_a;
    if (cw[7]) return m_mem[m_mar];
    if (cw[5]) return m_ir % 16;
    if (cw[9]) return m_pc;
    return 0;
  endfunction

  task automatic model_edge(input logic [11:0] cw, input bit pwe, input int paddr,
                            input int pdata, input bit r);
    int bus, ndrv, s;
    bus  = mbus(cw);
    s    = alu_sum(cw);
    ndrv = int'(cw[0]) + int'(cw[3]) + int'(cw[5]) + int'(cw[7]) + int'(cw[9]);
    if (pwe) m_mem[paddr] = pdata;
    if (r) begin
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
      m_carry = 0; m_zero = 0; m_halt = 0; m_err = 0;
      m_init = 1'b1;
    end else if (!m_halt && !pwe) begin
      m_err = (ndrv > 1);
      if (cw[8]) m_mar = bus % 16;
      if (cw[6]) m_ir = bus;
      if (cw[4]) begin
        m_a = bus;
        if (cw[0]) begin
          m_carry = (s >= 256);
          m_zero  = (s % 256 == 0);
        end
      end
      if (cw[2])  m_b = bus;
      if (cw[10]) m_pc = (m_pc + 1) % 16;
      if (cw[11]) m_halt = 1;
    end else begin
      m_err = 0;
    end
  endtask

  task automatic step(input logic [11:0] cw, input bit pwe = 0, input int paddr = 0,
                      input int pdata = 0, input bit r = 0);
    @(negedge clk);
    io.cw = cw; io.prog_we = pwe;
    io.prog_addr = paddr[3:0]; io.prog_data = pdata[7:0];
    rst = r;
    #1;
    if (m_init) check("bus_out", 32'(io.bus_out), 32'(mbus(cw)));
    model_edge(cw, pwe, paddr, pdata, r);
    @(posedge clk);
    #1;
    if (m_init) begin
      check("a_out",   32'(io.a_out),   32'(m_a));
      check("opcode",  32'(io.opcode),  32'(m_ir / 16));
      check("carry",   32'(io.carry),   32'(m_carry));
      check("zero",    32'(io.zero),    32'(m_zero));
      check("halted",  32'(io.halted),  32'(m_halt));
      check("bus_err", 32'(io.bus_err), 32'(m_err));
    end
  endtask

  task automatic fetch();
    step(PC_EN | MEM_LOAD);
    step(PC_INC);
    step(MEM_EN | IR_LOAD);
  endtask

  // Leaves MAR=0 and PC=0 with A and B set from RAM[0]
  task automatic load_ab(input int av, input int bv);
    step(12'h000, 0, 0, 0, 1);
    step(12'h000, 1, 0, av);
    step(MEM_EN | A_LOAD);
    step(12'h000, 1, 0, bv);
    step(MEM_EN | B_LOAD);
  endtask

  int prog [16] = '{8'h09, 8'h1A, 8'h2B, 8'hF0, 0, 0, 0, 0, 0, 8'h05, 8'h07, 8'h03, 0, 0, 0, 0};

  initial begin
    logic [11:0] cw;
    io.cw = '0; io.prog_we = 1'b0; io.prog_addr = '0; io.prog_data = '0;

    // 1: load program under reset, then run LDA/ADD/SUB/HLT
    step(12'h000, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(12'hFFF, 1, i, prog[i], 1);
    check("rst_a", 32'(io.a_out), 32'h0);
    check("rst_halted", 32'(io.halted), 32'h0);
    fetch(); step(IR_EN | MEM_LOAD); step(MEM_EN | A_LOAD);
    check("lda_a", 32'(io.a_out), 32'h05);
    fetch(); step(IR_EN | MEM_LOAD); step(MEM_EN | B_LOAD); step(ADDER_EN | A_LOAD);
    check("add_a", 32'(io.a_out), 32'h0C);
    fetch(); step(IR_EN | MEM_LOAD); step(MEM_EN | B_LOAD); step(SUB | ADDER_EN | A_LOAD);
    check("sub_a", 32'(io.a_out), 32'h09);
    check("sub_carry", 32'(io.carry), 32'h1);
    fetch(); step(HLT);
    check("hlt_halted", 32'(io.halted), 32'h1);
    check("hlt_opcode", 32'(io.opcode), 32'hF);

    // 2: FF + 01 wraps to zero with carry
    load_ab(8'hFF, 8'h01);
    step(ADDER_EN | A_LOAD);
    check("wrap_a", 32'(io.a_out), 32'h00);
    check("wrap_carry", 32'(io.carry), 32'h1);
    check("wrap_zero", 32'(io.zero), 32'h1);

    // 3: 00 - 01 borrows
    load_ab(8'h00, 8'h01);
    step(SUB | ADDER_EN | A_LOAD);
    check("borrow_a", 32'(io.a_out), 32'hFF);
    check("borrow_carry", 32'(io.carry), 32'h0);
    check("borrow_zero", 32'(io.zero), 32'h0);

    // 4: PC wraps from F to 0, MAR follows
    step(12'h000, 0, 0, 0, 1);
    step(12'h000, 1, 0, 8'hA5);
    step(12'h000, 1, 15, 8'h5A);
    for (int i = 0; i < 15; i++) step(PC_INC);
    step(PC_EN | MEM_LOAD);
    step(MEM_EN);
    check("pc_f_mem", 32'(io.bus_out), 32'h5A);
    step(PC_INC);
    step(PC_EN | MEM_LOAD);
    check("pc_wrap_bus", 32'(io.bus_out), 32'h00);
    step(MEM_EN);
    check("mar_zero_mem", 32'(io.bus_out), 32'hA5);

    // 5: two drivers: A wins over PC, bus_err pulses once
    load_ab(8'h3C, 8'h11);
    step(PC_INC); step(PC_INC);
    step(PC_EN | A_EN | B_LOAD);
    check("conflict_err", 32'(io.bus_err), 32'h1);
    step(SUB | ADDER_EN);
    check("conflict_b", 32'(io.bus_out), 32'h00);
    check("conflict_err_clear", 32'(io.bus_err), 32'h0);

    // 6: halted blocks loads, reset clears
    load_ab(8'h21, 8'h00);
    step(12'h000, 1, 0, 8'h55);
    step(HLT);
    step(MEM_EN | A_LOAD);
    check("halt_bus", 32'(io.bus_out), 32'h55);
    check("halt_a_hold", 32'(io.a_out), 32'h21);
    step(12'h000, 0, 0, 0, 1);
    check("rst2_a", 32'(io.a_out), 32'h0);
    check("rst2_halted", 32'(io.halted), 32'h0);
    check("rst2_opcode", 32'(io.opcode), 32'h0);

    // Random control words, program writes and resets
    for (int i = 0; i < 3000; i++) begin
      cw = 12'($urandom);
      if ($urandom_range(0, 63) != 0) cw[11] = 1'b0;
      if ($urandom_range(0, 7) == 0)
        step(cw, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 0);
      else if ($urandom_range(0, 49) == 0 || (m_halt != 0 && $urandom_range(0, 3) == 0))
        step(cw, 0, 0, 0, 1);
      else
        step(cw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
